// File: rtl/turn_scheduler_if.sv
// Bundle of run control, player buttons, hp feedback and action outputs for turn_scheduler.
`default_nettype none

interface turn_scheduler_if;
    logic       en;
    logic       punch1, kick1, wait1, jump1, left1, right1;
    logic       punch2, kick2, wait2, jump2, left2, right2;
    logic [1:0] hp1;
    logic [1:0] hp2;
    logic [2:0] act1;
    logic [2:0] act2;
    logic       act_valid;
    logic [7:0] turn_cnt;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output en, punch1, kick1, wait1, jump1, left1, right1,
        output punch2, kick2, wait2, jump2, left2, right2, hp1, hp2,
        input  act1, act2, act_valid, turn_cnt, busy, game_over, winner
    );

    modport slave (
        input  en, punch1, kick1, wait1, jump1, left1, right1,
        input  punch2, kick2, wait2, jump2, left2, right2, hp1, hp2,
        output act1, act2, act_valid, turn_cnt, busy, game_over, winner
    );
endinterface

`default_nettype wire

// File: rtl/turn_scheduler.sv
// ============================================================================
//  turn_scheduler : collects per-turn player actions, strobes them to the game
//                   core, and detects KO from the core's hp feedback.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module turn_scheduler #(
    parameter int TURN_CYCLES     = 4,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  wire                     clk,
    input  wire                     reset,
    turn_scheduler_if.slave         bus
);
    localparam int MAX_CYC = (TURN_CYCLES > COOLDOWN_CYCLES) ? TURN_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COLLECT  = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_COOLDOWN = 3'd3;
    localparam logic [2:0] S_OVER     = 3'd4;

    localparam logic [2:0] ACT_WAIT = 3'b110;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lat1, lat1_nxt, lat2, lat2_nxt;
    logic [2:0]       code1, code1_nxt, code2, code2_nxt;

    logic [2:0] act1, act1_nxt, act2, act2_nxt;
    logic       act_valid, act_valid_nxt;
    logic [7:0] turn_cnt, turn_cnt_nxt;
    logic       busy, busy_nxt;
    logic       game_over, game_over_nxt;
    logic [1:0] winner, winner_nxt;

    logic [2:0] enc1, enc2;
    logic       any1, any2;

    function automatic logic [2:0] encode(input logic p, input logic k, input logic j,
                                          input logic l, input logic r, input logic w);
        if (p)      return 3'b001;
        else if (k) return 3'b010;
        else if (j) return 3'b011;
        else if (l) return 3'b100;
        else if (r) return 3'b101;
        else if (w) return 3'b110;
        else        return 3'b000;
    endfunction

    assign enc1 = encode(bus.punch1, bus.kick1, bus.jump1, bus.left1, bus.right1, bus.wait1);
    assign enc2 = encode(bus.punch2, bus.kick2, bus.jump2, bus.left2, bus.right2, bus.wait2);
    assign any1 = |{bus.punch1, bus.kick1, bus.jump1, bus.left1, bus.right1, bus.wait1};
    assign any2 = |{bus.punch2, bus.kick2, bus.jump2, bus.left2, bus.right2, bus.wait2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat1      <= 1'b0;
            lat2      <= 1'b0;
            code1     <= 3'b000;
            code2     <= 3'b000;
            act1      <= 3'b000;
            act2      <= 3'b000;
            act_valid <= 1'b0;
            turn_cnt  <= 8'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat1      <= lat1_nxt;
            lat2      <= lat2_nxt;
            code1     <= code1_nxt;
            code2     <= code2_nxt;
            act1      <= act1_nxt;
            act2      <= act2_nxt;
            act_valid <= act_valid_nxt;
            turn_cnt  <= turn_cnt_nxt;
            busy      <= busy_nxt;
            game_over <= game_over_nxt;
            winner    <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat1_nxt  = lat1;
        lat2_nxt  = lat2;
        code1_nxt = code1;
        code2_nxt = code2;
        case (state)
            S_IDLE: begin
                if (bus.en) begin
                    state_nxt = S_COLLECT;
                    cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
                end
            end
            S_COLLECT: begin
                if (bus.en) begin
                    // Only the first pressing cycle of the window is captured.
                    if (!lat1 && any1) begin
                        lat1_nxt  = 1'b1;
                        code1_nxt = enc1;
                    end
                    if (!lat2 && any2) begin
                        lat2_nxt  = 1'b1;
                        code2_nxt = enc2;
                    end
                    if ((lat1_nxt && lat2_nxt) || (cnt == '0))
                        state_nxt = S_ISSUE;
                    else
                        cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ISSUE: begin
                state_nxt = S_COOLDOWN;
                cnt_nxt   = CNT_W'(COOLDOWN_CYCLES - 1);
                lat1_nxt  = 1'b0;
                lat2_nxt  = 1'b0;
                code1_nxt = 3'b000;
                code2_nxt = 3'b000;
            end
            S_COOLDOWN: begin
                if (cnt == '0) begin
                    if ((bus.hp1 == 2'd0) || (bus.hp2 == 2'd0)) begin
                        state_nxt = S_OVER;
                    end else if (bus.en) begin
                        state_nxt = S_COLLECT;
                        cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_OVER:  state_nxt = S_OVER;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the strobe lines up with ISSUE.
    always_comb begin
        act_valid_nxt = (state == S_COLLECT) && (state_nxt == S_ISSUE);
        act1_nxt      = act1;
        act2_nxt      = act2;
        turn_cnt_nxt  = turn_cnt;
        if (act_valid_nxt) begin
            act1_nxt = lat1_nxt ? code1_nxt : ACT_WAIT;
            act2_nxt = lat2_nxt ? code2_nxt : ACT_WAIT;
            if (turn_cnt != 8'hFF)
                turn_cnt_nxt = turn_cnt + 8'd1;
        end
        busy_nxt      = (state_nxt == S_COLLECT) || (state_nxt == S_ISSUE) ||
                        (state_nxt == S_COOLDOWN);
        game_over_nxt = (state_nxt == S_OVER);
        winner_nxt    = winner;
        if ((state == S_COOLDOWN) && (state_nxt == S_OVER))
            winner_nxt = {bus.hp1 == 2'd0, bus.hp2 == 2'd0};
    end

    assign bus.act1      = act1;
    assign bus.act2      = act2;
    assign bus.act_valid = act_valid;
    assign bus.turn_cnt  = turn_cnt;
    assign bus.busy      = busy;
    assign bus.game_over = game_over;
    assign bus.winner    = winner;

endmodule

`default_nettype wire

// File: tb/tb_turn_scheduler.sv
// Table-driven cycle vectors plus hand sequences for reset abort and draw.
`default_nettype none

module tb_turn_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   applied     = 0;
    int   miscompares = 0;

    turn_scheduler_if bus ();

    turn_scheduler #(.TURN_CYCLES(4), .COOLDOWN_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Button order: {punch, kick, jump, left, right, wait}
    typedef struct {
        logic       en;
        logic [5:0] b1;
        logic [5:0] b2;
        logic [1:0] hp1;
        logic [1:0] hp2;
        logic [18:0] exp; // {act1, act2, act_valid, turn_cnt, busy, game_over, winner}
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t mk(input logic en, input logic [5:0] b1, input logic [5:0] b2,
                                input logic [1:0] hp1, input logic [1:0] hp2,
                                input logic [2:0] a1, input logic [2:0] a2, input logic av,
                                input logic [7:0] tc, input logic busy, input logic go,
                                input logic [1:0] win);
        vec_t v;
        v.en = en; v.b1 = b1; v.b2 = b2; v.hp1 = hp1; v.hp2 = hp2;
        v.exp = {a1, a2, av, tc, busy, go, win};
        return v;
    endfunction

    task automatic drive(input logic en, input logic [5:0] b1, input logic [5:0] b2,
                         input logic [1:0] hp1, input logic [1:0] hp2);
        bus.en = en;
        {bus.punch1, bus.kick1, bus.jump1, bus.left1, bus.right1, bus.wait1} = b1;
        {bus.punch2, bus.kick2, bus.jump2, bus.left2, bus.right2, bus.wait2} = b2;
        bus.hp1 = hp1;
        bus.hp2 = hp2;
    endtask

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = {bus.act1, bus.act2, bus.act_valid, bus.turn_cnt, bus.busy, bus.game_over, bus.winner};
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %05h want %05h", name, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 6'b000000, 6'b000000, 3, 3, 0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(1, 6'b000010, 6'b000100, 3, 3, 5, 4, 1, 1, 1, 0, 0);
        vecs[2]  = mk(1, 6'b000000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[3]  = mk(1, 6'b000000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[4]  = mk(1, 6'b000000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[5]  = mk(1, 6'b100000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[6]  = mk(1, 6'b000000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[7]  = mk(1, 6'b000000, 6'b000000, 3, 3, 5, 4, 0, 1, 1, 0, 0);
        vecs[8]  = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 6, 1, 2, 1, 0, 0);
        vecs[9]  = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 6, 0, 2, 1, 0, 0);
        vecs[10] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 6, 0, 2, 1, 0, 0);
        vecs[11] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 6, 0, 2, 1, 0, 0);
        vecs[12] = mk(1, 6'b110000, 6'b001000, 3, 3, 1, 3, 1, 3, 1, 0, 0);
        vecs[13] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[14] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[15] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[16] = mk(1, 6'b010000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[17] = mk(0, 6'b100000, 6'b100000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[18] = mk(0, 6'b000000, 6'b000001, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[19] = mk(1, 6'b100000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[20] = mk(1, 6'b000000, 6'b000000, 3, 3, 1, 3, 0, 3, 1, 0, 0);
        vecs[21] = mk(1, 6'b000000, 6'b000000, 3, 3, 2, 6, 1, 4, 1, 0, 0);
        vecs[22] = mk(1, 6'b000000, 6'b000000, 3, 3, 2, 6, 0, 4, 1, 0, 0);
        vecs[23] = mk(0, 6'b000000, 6'b000000, 3, 3, 2, 6, 0, 4, 1, 0, 0);
        vecs[24] = mk(0, 6'b000000, 6'b000000, 3, 3, 2, 6, 0, 4, 0, 0, 0);
        vecs[25] = mk(0, 6'b100000, 6'b000000, 3, 3, 2, 6, 0, 4, 0, 0, 0);
        vecs[26] = mk(1, 6'b000000, 6'b000000, 3, 3, 2, 6, 0, 4, 1, 0, 0);
        vecs[27] = mk(1, 6'b000001, 6'b000010, 3, 3, 6, 5, 1, 5, 1, 0, 0);
        vecs[28] = mk(1, 6'b000000, 6'b000000, 3, 3, 6, 5, 0, 5, 1, 0, 0);
        vecs[29] = mk(1, 6'b000000, 6'b000000, 3, 3, 6, 5, 0, 5, 1, 0, 0);
        vecs[30] = mk(1, 6'b000000, 6'b000000, 3, 0, 6, 5, 0, 5, 0, 1, 1);
        vecs[31] = mk(1, 6'b100000, 6'b100000, 3, 0, 6, 5, 0, 5, 0, 1, 1);
        vecs[32] = mk(1, 6'b100000, 6'b100000, 3, 0, 6, 5, 0, 5, 0, 1, 1);

        // Reset held with buttons toggling
        drive(1, 6'b111111, 6'b111111, 3, 3);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, (i % 2 == 0) ? 6'b101010 : 6'b010101, (i % 2 == 0) ? 6'b010101 : 6'b101010, 3, 3);
            @(posedge clk); #1;
            check($sformatf("reset_hold_%0d", i), 19'h0);
        end
        drive(0, 6'b000000, 6'b000000, 3, 3);
        reset = 1'b1;

        for (int i = 0; i < 33; i++) begin
            drive(vecs[i].en, vecs[i].b1, vecs[i].b2, vecs[i].hp1, vecs[i].hp2);
            @(posedge clk); #1;
            check($sformatf("vec_%0d", i), vecs[i].exp);
        end

        // Async reset from OVER clears everything immediately
        #2 reset = 1'b0;
        #1 check("reset_from_over", 19'h0);
        drive(1, 6'b000000, 6'b000000, 3, 3);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("restart_collect", {3'd0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0, 2'b00});
        drive(1, 6'b100000, 6'b000000, 3, 3);
        @(posedge clk); #1;
        check("latch_before_abort", {3'd0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0, 2'b00});
        drive(1, 6'b000000, 6'b000000, 3, 3);
        #2 reset = 1'b0;
        #1 check("abort_mid_collect", 19'h0);
        @(posedge clk); #1;
        check("abort_no_strobe", 19'h0);
        @(negedge clk) reset = 1'b1;

        // Fresh turn with no presses: the aborted punch must not reappear
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge clk); #1;
                if (bus.act_valid) seen = 1;
            end
            if (!seen) begin
                applied++; miscompares++;
                $display("FAIL wait_strobe: got no act_valid want act_valid within 10 cycles");
            end else begin
                check("post_abort_turn", {3'd6, 3'd6, 1'b1, 8'd1, 1'b1, 1'b0, 2'b00});
            end
        end

        // Draw: both hp reach zero
        drive(1, 6'b000000, 6'b000000, 0, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(posedge clk); #1;
                if (bus.game_over) seen = 1;
            end
            if (!seen) begin
                applied++; miscompares++;
                $display("FAIL wait_over: got no game_over want game_over within 10 cycles");
            end else begin
                check("draw", {3'd6, 3'd6, 1'b0, 8'd1, 1'b0, 1'b1, 2'b11});
            end
        end
        drive(1, 6'b010000, 6'b001000, 0, 0);
        repeat (5) @(posedge clk);
        #1 check("over_terminal", {3'd6, 3'd6, 1'b0, 8'd1, 1'b0, 1'b1, 2'b11});

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
